opc5_uart: RTL and testbench
============================

Name: opc5_uart

Overview:
- Memory-mapped UART peripheral on the OPC5 CPU bus (address / bidirectional data / rnw).
- Decodes two word addresses.
- Byte writes from the CPU go into a TX FIFO and are serialised on txd as 8N1 frames.
- Bytes received on rxd are deserialised into a holding register that the CPU polls and reads.
- The CPU has no wait input: reads are combinational within the bus cycle, and writes are captured on the clk edge that ends the cycle.

Parameters:
- BASE_ADDR, 16'hFE00: word address of DATA register; STATUS is at BASE_ADDR+1.
- CLK_DIV, 16'd434: clk cycles per bit period (must be >= 4).
- TX_DEPTH, 8: TX FIFO entries (power of two, >= 2).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- address  input  16  CPU word address
- data  inout  16  CPU data bus
- rnw  input  1  1 = read cycle, 0 = write cycle
- rxd  input  1  serial receive line, asynchronous to clk
- txd  output  1  serial transmit line

Behaviour:
- Reset and select:
  - Reset is asynchronous, active-high, and applies in any state, including mid-frame.
  - On reset: txd=1, TX FIFO empty, TX FSM IDLE, RX FSM IDLE, rx_valid=0, rx_overrun=0, rx_data=0, baud counters=0.
  - sel_d = (address==BASE_ADDR); sel_s = (address==BASE_ADDR+1).
- Read path:
  - data driven only when rnw=1 and (sel_d|sel_s); otherwise 16'bz. The path is purely combinational from address/rnw/state.
  - DATA read value: {8'h00, rx_data}.
  - STATUS read value: {12'h000, rx_overrun, rx_valid, tx_full, tx_busy}.
    - tx_busy = FIFO non-empty or TX FSM not IDLE.
- Read side effects (rising edge with rnw=1 and sel_d):
  - Clear rx_valid and rx_overrun.
  - If an RX byte completes in the same cycle, the new byte wins: rx_valid=1, rx_overrun=0.
- Write (rising edge with rnw=0 and sel_d): push data[7:0] into the TX FIFO.
  - Push when full is dropped silently. Full is evaluated before any same-cycle pop.
  - Writes to STATUS are ignored.
  - Reads of STATUS have no side effects.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register, load the bit counter with CLK_DIV-1, set txd=0, go to START.
  - Each state holds txd for exactly CLK_DIV clk cycles.
  - START -> DATA: 8 bits, LSB first.
  - DATA -> STOP: txd=1 for CLK_DIV cycles.
  - STOP -> IDLE, or directly to START if the FIFO is non-empty, with no idle gap.
  - Frame length is exactly 10*CLK_DIV cycles.
  - Latency: txd falls on the 2nd rising edge after the write edge when the FIFO is empty and IDLE.
- RX path:
  - rxd passes through a 2-flop synchroniser before use.
  - IDLE: on a synchronised falling edge, wait CLK_DIV/2 cycles and re-sample. If high (glitch), return to IDLE; if low, go to DATA.
  - DATA: sample 8 bits, one every CLK_DIV cycles at mid-bit, LSB first.
  - STOP: sample after one further CLK_DIV.
    - Stop bit high: load rx_data and set rx_valid. If rx_valid was already 1, also set rx_overrun; the new byte overwrites the old one.
    - Stop bit low (framing error): discard the byte; flags unchanged.
  - After STOP, return to IDLE and look for the next start edge.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(TX_DEPTH); pointers wrap naturally.
  - full = MSBs differ and low bits equal; empty = pointers equal.
  - Simultaneous push and pop when not full: both occur and the count is unchanged.

Test Plan (CLK_DIV=4, TX_DEPTH=4):
- Reset release, idle bus -> txd=1, STATUS read returns 16'h0000, data is Z when address=16'h1234.
- Write 16'h0155 to FE00 -> txd low 2nd edge later; then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high; STATUS bit0 returns to 0 after 40 cycles.
- Five back-to-back writes (A0..A4) while IDLE -> first pops immediately, A1..A4 fill FIFO, STATUS bit1=1. A sixth write is dropped. Exactly 5 frames, contiguous, with no gap between stop and start.
- Drive rxd frame 8'hC3 with valid stop -> STATUS=16'h0004; DATA read returns 16'h00C3; next STATUS read = 16'h0000.
- Two RX frames 8'h11 then 8'h22 without reading -> STATUS=16'h000C, DATA returns 16'h0022, flags clear after the read. A frame with stop bit low -> flags unchanged. A 1-cycle rxd low glitch -> no byte received.
- Assert reset mid TX frame and mid RX frame -> txd=1 immediately (asynchronously), FIFO empty, STATUS=0 after release; next write transmits a correct full frame.

Source files
------------

// File: rtl/opc5_uart_if.sv
// OPC5 CPU bus command lines (address and read/not-write).
// The bidirectional data lines stay a plain inout on the peripheral.
interface opc5_uart_if;
    logic [15:0] address;
    logic        rnw;

    modport master (
        output address,
        output rnw
    );

    modport slave (
        input address,
        input rnw
    );
endinterface

// File: rtl/opc5_uart.sv
// Memory-mapped 8N1 UART for the OPC5 bus: DATA/STATUS registers,
// TX FIFO with serialiser, and a polled RX holding register.
module opc5_uart #(
    parameter logic [15:0] BASE_ADDR = 16'hFE00,
    parameter logic [15:0] CLK_DIV   = 16'd434,
    parameter int          TX_DEPTH  = 8
) (
    input  logic         clk,
    input  logic         reset,
    opc5_uart_if.slave   bus,
    inout  wire   [15:0] data,
    input  logic         rxd,
    output logic         txd
);
    localparam int          AW        = $clog2(TX_DEPTH);
    localparam logic [15:0] BIT_LAST  = CLK_DIV - 16'd1;
    localparam logic [15:0] HALF_LAST = (CLK_DIV >> 1) - 16'd1;

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    logic        w_sel_d;
    logic        w_sel_s;
    logic        w_rd_d;
    logic        w_wr_d;
    logic [15:0] w_rdata;
    logic        w_unused;

    assign w_sel_d  = (bus.address == BASE_ADDR);
    assign w_sel_s  = (bus.address == BASE_ADDR + 16'd1);
    assign w_rd_d   = bus.rnw & w_sel_d;
    assign w_wr_d   = ~bus.rnw & w_sel_d;
    assign w_unused = &{1'b0, data[15:8]};

    // ---------------- TX FIFO ----------------
    logic [7:0]  r_mem [TX_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = w_wr_d & ~w_full;
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    // FIFO pointers; full is judged before any same-cycle pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // FIFO storage, no reset needed since pointers gate its use
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= data[7:0];
    end

    // ---------------- TX serialiser ----------------
    tx_state_t   r_tx_state, w_tx_state_n;
    logic [15:0] r_tx_cnt, w_tx_cnt_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_shift, w_tx_shift_n;
    logic        r_tx_pre, w_tx_pre_n;
    logic        r_txd;
    logic        w_tx_zero;
    logic        w_tx_busy;

    assign w_tx_zero = (r_tx_cnt == 16'd0);
    assign w_tx_busy = ~w_empty | (r_tx_state != TX_IDLE);
    assign txd       = r_txd;

    // TX state register; txd goes through one extra retiming flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_pre   <= 1'b1;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_pre   <= w_tx_pre_n;
            r_txd      <= r_tx_pre;
        end
    end

    // TX next-state: each state holds its line level for CLK_DIV cycles
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_pre_n   = r_tx_pre;
        w_pop        = 1'b0;
        if (r_tx_state != TX_IDLE && !w_tx_zero)
            w_tx_cnt_n = r_tx_cnt - 16'd1;
        unique case (r_tx_state)
            TX_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_tx_shift_n = w_head;
                    w_tx_cnt_n   = BIT_LAST;
                    w_tx_pre_n   = 1'b0;
                    w_tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_zero) begin
                    w_tx_state_n = TX_DATA;
                    w_tx_cnt_n   = BIT_LAST;
                    w_tx_bit_n   = 3'd0;
                    w_tx_pre_n   = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tx_zero) begin
                    w_tx_cnt_n = BIT_LAST;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = TX_STOP;
                        w_tx_pre_n   = 1'b1;
                    end else begin
                        w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                        w_tx_pre_n   = r_tx_shift[1];
                        w_tx_bit_n   = r_tx_bit + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_zero) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_tx_shift_n = w_head;
                        w_tx_cnt_n   = BIT_LAST;
                        w_tx_pre_n   = 1'b0;
                        w_tx_state_n = TX_START;
                    end else begin
                        w_tx_pre_n   = 1'b1;
                        w_tx_state_n = TX_IDLE;
                    end
                end
            end
            default: w_tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- RX deserialiser ----------------
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    rx_state_t   r_rx_state, w_rx_state_n;
    logic [15:0] r_rx_cnt, w_rx_cnt_n;
    logic [2:0]  r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_rx_shift, w_rx_shift_n;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_rx_over;
    logic        w_rx_done;
    logic        w_rx_zero;
    logic        w_rx_fall;

    assign w_rx_zero = (r_rx_cnt == 16'd0);
    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

    // rxd synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
        end
    end

    // RX next-state: sample mid-bit, half a bit after the start edge
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_done    = 1'b0;
        if (r_rx_state != RX_IDLE && !w_rx_zero)
            w_rx_cnt_n = r_rx_cnt - 16'd1;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_state_n = RX_START;
                    w_rx_cnt_n   = HALF_LAST;
                end
            end
            RX_START: begin
                if (w_rx_zero) begin
                    if (r_rx_s2) begin
                        w_rx_state_n = RX_IDLE;
                    end else begin
                        w_rx_state_n = RX_DATA;
                        w_rx_cnt_n   = BIT_LAST;
                        w_rx_bit_n   = 3'd0;
                    end
                end
            end
            RX_DATA: begin
                if (w_rx_zero) begin
                    w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_cnt_n   = BIT_LAST;
                    if (r_rx_bit == 3'd7)
                        w_rx_state_n = RX_STOP;
                    else
                        w_rx_bit_n = r_rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (w_rx_zero) begin
                    w_rx_state_n = RX_IDLE;
                    w_rx_done    = r_rx_s2;
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    // RX holding register and flags; a completing byte beats a read-clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_over  <= 1'b0;
        end else if (w_rx_done) begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            r_rx_over  <= w_rd_d ? 1'b0 : r_rx_valid;
        end else if (w_rd_d) begin
            r_rx_valid <= 1'b0;
            r_rx_over  <= 1'b0;
        end
    end

    // ---------------- Read path ----------------
    assign w_rdata = w_sel_d ? {8'h00, r_rx_data}
                             : {12'h000, r_rx_over, r_rx_valid,
                                w_full, w_tx_busy};

    assign data = (bus.rnw && (w_sel_d || w_sel_s)) ? w_rdata : 16'bz;
endmodule

// File: tb/tb_opc5_uart.sv
// Self-checking bench for opc5_uart with CLK_DIV=4, TX_DEPTH=4.
// A frame-level model predicts txd every cycle and every register read.
module tb_opc5_uart;
    localparam logic [15:0] BASE  = 16'hFE00;
    localparam logic [15:0] STAT  = 16'hFE01;
    localparam int          DIV   = 4;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic        txd;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dout = 16'h0000;
    tri1  [15:0] data;

    int n_checks = 0;
    int n_fail   = 0;

    opc5_uart_if u_bus ();

    assign data = tb_oe ? tb_dout : 16'bz;

    opc5_uart #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (16'd4),
        .TX_DEPTH  (DEPTH)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (u_bus),
        .data    (data),
        .rxd     (rxd),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    // model state
    logic [7:0] mq [$];
    bit         m_act = 1'b0;
    int         m_p = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_pre = 1'b1;
    logic       exp_txd = 1'b1;
    logic       m_rx_valid = 1'b0;
    logic       m_rx_over = 1'b0;
    logic [7:0] m_rx_data = 8'h00;
    int         sz0;
    bit         wr_now;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic bitval(input int p, input logic [7:0] b);
        int k;
        k = p / DIV;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        logic full;
        logic busy;
        full = (mq.size() == DEPTH);
        busy = (mq.size() != 0) || m_act;
        if (a == BASE) return {8'h00, m_rx_data};
        return {12'h000, m_rx_over, m_rx_valid, full, busy};
    endfunction

    // frame-level TX model: a frame is 10*DIV cycles, back-to-back
    // frames when bytes are queued, txd shown one edge after start
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_act   = 1'b0;
                m_p     = 0;
                m_pre   = 1'b1;
                exp_txd = 1'b1;
            end else begin
                sz0    = mq.size();
                wr_now = !u_bus.rnw && (u_bus.address == BASE);
                exp_txd = m_pre;
                if (m_act) begin
                    m_p++;
                    if (m_p == 10 * DIV) m_act = 1'b0;
                end
                if (!m_act && mq.size() != 0) begin
                    m_byte = mq.pop_front();
                    m_act  = 1'b1;
                    m_p    = 0;
                end
                if (wr_now && sz0 < DEPTH) mq.push_back(tb_dout[7:0]);
                m_pre = m_act ? bitval(m_p, m_byte) : 1'b1;
            end
        end
    end

    // compare txd against the model every cycle
    initial begin
        forever begin
            @(negedge clk);
            chk("txd", {15'h0, txd}, {15'h0, exp_txd});
        end
    end

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        u_bus.address = a;
        u_bus.rnw     = 1'b0;
        tb_dout       = d;
        tb_oe         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_bus.address = 16'h0000;
        u_bus.rnw     = 1'b1;
        tb_oe         = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] lit,
                      input string nm);
        logic [15:0] m;
        u_bus.address = a;
        u_bus.rnw     = 1'b1;
        tb_oe         = 1'b0;
        #1;
        m = model_read(a);
        chk(nm, data, m);
        chk({nm, "_pin"}, data, lit);
        @(posedge clk);
        if (a == BASE) begin
            m_rx_valid = 1'b0;
            m_rx_over  = 1'b0;
        end
        @(negedge clk);
        u_bus.address = 16'h0000;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        if (stop_ok) begin
            m_rx_over  = m_rx_valid;
            m_rx_valid = 1'b1;
            m_rx_data  = b;
        end
    endtask

    logic [9:0] pat55;

    initial begin
        u_bus.address = 16'h0000;
        u_bus.rnw     = 1'b1;
        pat55 = 10'b1_01010101_0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_txd", {15'h0, txd}, 16'h0001);
        rd(STAT, 16'h0000, "rst_status");
        u_bus.address = 16'h1234;
        #1;
        chk("z_other_addr", data, 16'hFFFF);
        @(negedge clk);
        wr(STAT, 16'h0077);
        rd(STAT, 16'h0000, "status_write_ignored");

        // single frame 0x55
        wr(BASE, 16'h0155);
        @(negedge clk);
        chk("lat_edge1", {15'h0, txd}, 16'h0001);
        @(negedge clk);
        chk("lat_edge2_start", {15'h0, txd}, {15'h0, pat55[0]});
        for (int k = 1; k < 10; k++) begin
            repeat (DIV) @(negedge clk);
            chk($sformatf("bit55_%0d", k), {15'h0, txd},
                {15'h0, pat55[k]});
        end
        repeat (2) @(negedge clk);
        rd(STAT, 16'h0001, "busy_last");
        rd(STAT, 16'h0000, "busy_done");

        // burst of six writes, last one dropped
        for (int i = 0; i < 6; i++) wr(BASE, 16'h00A0 + 16'(i));
        rd(STAT, 16'h0003, "fifo_full");
        repeat (194) @(negedge clk);
        rd(STAT, 16'h0001, "burst_last");
        rd(STAT, 16'h0000, "burst_done");

        // receive path
        send_rx(8'hC3, 1'b1);
        rd(STAT, 16'h0004, "rx_c3_status");
        rd(BASE, 16'h00C3, "rx_c3_data");
        rd(STAT, 16'h0000, "rx_c3_clr");

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd(STAT, 16'h000C, "rx_over_status");
        rd(BASE, 16'h0022, "rx_over_data");
        rd(STAT, 16'h0000, "rx_over_clr");

        send_rx(8'h5A, 1'b1);
        send_rx(8'hF0, 1'b0);
        rd(STAT, 16'h0004, "rx_ferr_status");
        rd(BASE, 16'h005A, "rx_ferr_data");

        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        rd(STAT, 16'h0000, "rx_glitch_status");
        rd(BASE, 16'h005A, "rx_glitch_data");

        // reset in the middle of TX and RX frames
        wr(BASE, 16'h0000);
        repeat (10) @(negedge clk);
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_frame_low", {15'h0, txd}, 16'h0000);
        #2;
        reset      = 1'b1;
        m_rx_valid = 1'b0;
        m_rx_over  = 1'b0;
        m_rx_data  = 8'h00;
        #1;
        chk("async_rst_txd", {15'h0, txd}, 16'h0001);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rxd   = 1'b1;
        @(negedge clk);
        rd(STAT, 16'h0000, "post_rst_status");
        rd(BASE, 16'h0000, "post_rst_data");
        wr(BASE, 16'h00A5);
        @(negedge clk);
        chk("post_rst_edge1", {15'h0, txd}, 16'h0001);
        @(negedge clk);
        chk("post_rst_start", {15'h0, txd}, 16'h0000);
        repeat (42) @(negedge clk);
        rd(STAT, 16'h0000, "post_rst_done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
